// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

    // ASSERT holds the downstream reset low; RUN releases it.
    typedef enum logic {
        ASSERT = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Encoding of last_cause; 2'b11 is never produced.
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    // Width of a down/up counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of reset request inputs, reset outputs and debug observation
// signals between the reset sequencer and its environment.
//
// Request protocol: ext_rst_req is a raw level, asynchronous to clk, and
// is only acted on after synchronization and debounce. sw_rst_req is a
// single-cycle pulse synchronous to clk; it is consumed on the edge that
// samples it in RUN and dropped without effect in ASSERT. There is no
// back-pressure: a request is never queued, so the requester needs no
// ready signal.
interface reset_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int DEB_W = 8
);
    import reset_seq_pkg::*;

    logic             ext_rst_req;
    logic             sw_rst_req;
    logic             rst_n_out;
    logic             rst_active;
    logic [1:0]       last_cause;
    logic [CNT_W-1:0] reset_count;

    // Debug observation of the sequencer state and debounce progress.
    state_t           dbg_state;
    logic [DEB_W-1:0] dbg_debounce;

    // Environment side: issues requests, observes reset outputs.
    modport master (
        output ext_rst_req,
        output sw_rst_req,
        input  rst_n_out,
        input  rst_active,
        input  last_cause,
        input  reset_count,
        input  dbg_state,
        input  dbg_debounce
    );

    // Sequencer side.
    modport slave (
        input  ext_rst_req,
        input  sw_rst_req,
        output rst_n_out,
        output rst_active,
        output last_cause,
        output reset_count,
        output dbg_state,
        output dbg_debounce
    );

endinterface

// File: rtl/reset_req_sync.sv
// Multi-flop bit synchronizer for an asynchronous level, cleared to 0
// asynchronously by rst.
module reset_req_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw level through the chain; bit 0 is the metastable stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges power-on reset, a debounced external request and
// a software pulse into one stretched active-low reset for the counter
// datapath, and records the reset cause and a saturating event count.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STRETCH_CYCLES  = 8,
    parameter int CNT_W           = 8,
    parameter int DBG_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    reset_sequencer_if.slave   bus
);

    localparam int DEB_CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int STR_CW = cnt_width(STRETCH_CYCLES - 1);

    // Debounce completes on the edge that would bring the count to
    // DEBOUNCE_CYCLES, so compare against one less.
    localparam logic [DEB_CW-1:0] DEB_LAST = DEB_CW'(DEBOUNCE_CYCLES - 1);
    // Stretch counts remaining edges; at 0 the next quiet edge releases.
    localparam logic [STR_CW-1:0] STR_LOAD = STR_CW'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            r_state;
    logic [STR_CW-1:0] r_stretch;
    logic [DEB_CW-1:0] r_deb;
    logic [1:0]        r_cause;
    logic [CNT_W-1:0]  r_count;
    logic              r_rst_n;
    logic              r_active;

    state_t            w_state;
    logic [STR_CW-1:0] w_stretch;
    logic [DEB_CW-1:0] w_deb;
    logic [1:0]        w_cause;
    logic [CNT_W-1:0]  w_count;
    logic              w_ext_sync;
    logic              w_ext_accept;
    logic              w_event;

    reset_req_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.ext_rst_req),
        .o_q (w_ext_sync)
    );

    // Next-state logic: stretch countdown in ASSERT, debounce and request
    // acceptance in RUN.
    always_comb begin
        w_state      = r_state;
        w_stretch    = r_stretch;
        w_deb        = r_deb;
        w_cause      = r_cause;
        w_count      = r_count;
        w_ext_accept = 1'b0;
        w_event      = 1'b0;

        case (r_state)
            ASSERT: begin
                // Requests during reset only lengthen it; nothing is logged.
                w_deb = '0;
                if (w_ext_sync) begin
                    w_stretch = STR_LOAD;
                end else if (r_stretch == '0) begin
                    w_state = RUN;
                end else begin
                    w_stretch = r_stretch - 1'b1;
                end
            end

            RUN: begin
                if (w_ext_sync) begin
                    if (r_deb == DEB_LAST) begin
                        w_ext_accept = 1'b1;
                    end else begin
                        w_deb = r_deb + 1'b1;
                    end
                end else begin
                    w_deb = '0;
                end

                // An ext acceptance and a sw pulse on the same edge are one
                // event attributed to the external source.
                w_event = w_ext_accept | bus.sw_rst_req;
                if (w_event) begin
                    w_state   = ASSERT;
                    w_stretch = STR_LOAD;
                    w_deb     = '0;
                    w_cause   = w_ext_accept ? CAUSE_EXT : CAUSE_SW;
                    if (r_count != CNT_MAX) begin
                        w_count = r_count + 1'b1;
                    end
                end
            end

            default: begin
                w_state   = ASSERT;
                w_stretch = STR_LOAD;
                w_deb     = '0;
            end
        endcase
    end

    // State and output registers; rst asserts the output reset at once and
    // restarts the sequence as a power-on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ASSERT;
            r_stretch <= STR_LOAD;
            r_deb     <= '0;
            r_cause   <= CAUSE_POR;
            r_count   <= '0;
            r_rst_n   <= 1'b0;
            r_active  <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_stretch <= w_stretch;
            r_deb     <= w_deb;
            r_cause   <= w_cause;
            r_count   <= w_count;
            r_rst_n   <= (w_state == RUN);
            r_active  <= (w_state == ASSERT);
        end
    end

    assign bus.rst_n_out    = r_rst_n;
    assign bus.rst_active   = r_active;
    assign bus.last_cause   = r_cause;
    assign bus.reset_count  = r_count;
    assign bus.dbg_state    = r_state;
    assign bus.dbg_debounce = DBG_W'(r_deb);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Upstream reset-generation stage for the counter datapath.
- Merges power-on reset, an asynchronous external reset request (button or pin) and a synchronous software reset pulse into one clean active-low reset, rst_n_out, for the downstream counter block.
- rst_n_out asserts asynchronously on power-on, deasserts synchronously and is stretched to a minimum width.
- Records the reset cause and a saturating reset-event count.

Parameters:
SYNC_STAGES, 2, synchronizer flops on ext_rst_req (>=2)
DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles needed to accept ext_rst_req (>=1)
STRETCH_CYCLES, 8, minimum low width of rst_n_out in clk cycles (>=2)
CNT_W, 8, width of reset_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high power-on reset
ext_rst_req  input  1  asynchronous active-high raw external reset request
sw_rst_req  input  1  synchronous single-cycle software reset pulse
rst_n_out  output  1  active-low reset to the downstream counter; async assert on rst, sync deassert
rst_active  output  1  registered, equal to ~rst_n_out
last_cause  output  2  00 POR, 01 EXT, 10 SW, 11 unused
reset_count  output  CNT_W  count of EXT+SW reset events, saturating

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, on rst.
- rst=1 forces, immediately and independent of clk:
  - rst_n_out=0, rst_active=1, state=ASSERT, stretch counter loaded
  - synchronizer flops=0, debounce counter=0
  - last_cause=00, reset_count=0
- States:
  - ASSERT: rst_n_out=0.
  - RUN: rst_n_out=1.
- ASSERT to RUN:
  - The stretch counter decrements each edge.
  - While ext_sync (synchronizer output) is sampled 1, the counter reloads.
  - rst_n_out rises on the STRETCH_CYCLES-th edge after rst deasserts, or after the last edge that sampled ext_sync=1.
  - Default: the 8th edge.
- ext path:
  - ext_rst_req passes through SYNC_STAGES flops to give ext_sync.
  - In RUN, the debounce counter increments while ext_sync=1 and clears to 0 on any ext_sync=0.
  - On the edge where the count reaches DEBOUNCE_CYCLES: go to ASSERT, rst_n_out=0, last_cause=01, reset_count+1.
  - Total latency from ext_rst_req rising to rst_n_out falling is SYNC_STAGES+DEBOUNCE_CYCLES edges (default 6).
- sw path:
  - sw_rst_req=1 sampled in RUN: ASSERT on that same edge, last_cause=10, reset_count+1.
  - rst_n_out rises STRETCH_CYCLES edges later.
- Simultaneous ext acceptance and sw_rst_req on the same edge: one event, last_cause=01, reset_count+1 only once.
- In ASSERT:
  - sw_rst_req is ignored.
  - ext_sync=1 only extends the stretch.
  - last_cause and reset_count are unchanged.
  - The debounce counter is held at 0.
- reset_count saturates at 2^CNT_W-1; further events still assert reset but the count does not wrap.
- rst asserted mid-ASSERT or mid-debounce: the async clear above applies, and the sequence restarts as POR.
- rst_n_out is driven directly from a flop. There is no combinational path from the inputs.

Decomposition:
- Package reset_seq_pkg:
  - state enum {ASSERT, RUN}
  - cause localparams CAUSE_POR=2'b00, CAUSE_EXT=2'b01, CAUSE_SW=2'b10
- One sub-module, reset_req_sync: a SYNC_STAGES-deep bit synchronizer with async active-high clear. Debounce, stretch and the FSM stay in the top level.

Test Plan:
- POR: rst=1 for 12 ns, then 0 -> rst_n_out=0 throughout, last_cause=00, reset_count=0; rst_n_out=1 on the 8th rising edge after rst falls.
- Glitch: ext_rst_req high for 3 cycles -> rst_n_out stays 1, reset_count stays 0, debounce counter returns to 0.
- Ext held: ext_rst_req high for 10 cycles -> rst_n_out falls on the 6th edge after the rise, last_cause=01, reset_count=1; rst_n_out rises 8 edges after the last ext_sync=1 sample.
- SW: one-cycle sw_rst_req in RUN -> rst_n_out=0 on that edge and 1 eight edges later, last_cause=10, reset_count+1; a second pulse 3 cycles later is ignored, count unchanged.
- Simultaneous: sw_rst_req on the same edge the ext debounce completes -> last_cause=01, reset_count increments by exactly 1.
- Reset mid-operation and saturation: rst=1 during ASSERT -> immediate clear, reset_count=0, last_cause=00. Then 300 sw pulses spaced 10 cycles apart -> reset_count=255, rst_n_out still pulses for every request.
